vc_test_rand_delay: RTL and testbench

// Single-entry val/rdy pipeline stage inserting a pseudo-random number of

---
 rtl/vc_test_rand_delay.sv | 102 ++++++++++
 tb/tb_vc_test_rand_delay.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_test_rand_delay.sv
// Single-entry val/rdy stage that holds each message for a pseudo-random number
// of idle cycles (16-bit Galois LFSR) before offering it downstream.
module vc_test_rand_delay #(
    parameter int unsigned p_msg_sz    = 1,
    parameter int unsigned p_max_delay = 0,
    parameter logic [15:0] p_seed      = 16'hb1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [p_msg_sz-1:0] in_msg,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [p_msg_sz-1:0] out_msg
);

    typedef enum logic [1:0] {StIdle, StDelay, StHold} state_e;

    localparam logic [15:0] LfsrTaps = 16'hb400;
    localparam logic [8:0]  DelayMod = 9'(p_max_delay + 1);

    state_e              state;
    logic [7:0]          cnt;
    logic [p_msg_sz-1:0] msg_buf;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [7:0]          delay;
    logic                in_xfer;
    logic                out_xfer;

    // Delay is drawn from the LFSR value before it advances for this message.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LfsrTaps : 16'h0000);
        delay     = 8'({1'b0, lfsr[7:0]} % DelayMod);
    end

    // All outputs are forced low while reset is asserted.
    always_comb begin
        in_rdy  = 1'b0;
        out_val = 1'b0;
        out_msg = '0;
        if (reset) begin
            out_msg = msg_buf;
            case (state)
                StIdle:  in_rdy = 1'b1;
                StHold: begin
                    in_rdy  = out_rdy;
                    out_val = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_xfer  = in_val & in_rdy;
    assign out_xfer = out_val & out_rdy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= StIdle;
            cnt     <= '0;
            msg_buf <= '0;
            lfsr    <= p_seed;
        end else begin
            if (in_xfer) begin
                msg_buf <= in_msg;
                lfsr    <= lfsr_next;
            end
            case (state)
                // HOLD may hand off and capture the next message on the same edge.
                StIdle, StHold: begin
                    if (in_xfer) begin
                        if (delay == 8'd0) begin
                            state <= StHold;
                        end else begin
                            cnt   <= delay - 8'd1;
                            state <= StDelay;
                        end
                    end else if (out_xfer) begin
                        state <= StIdle;
                    end
                end
                StDelay: begin
                    if (cnt == 8'd0) begin
                        state <= StHold;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_hold_stable: assert property (@(posedge clk)
        (out_val && !out_rdy) |=> (!reset || (out_val && out_msg == $past(out_msg))));
    a_lfsr_nonzero: assert property (@(posedge clk) reset |-> (lfsr != 16'h0000));
`endif

endmodule

// File: tb/tb_vc_test_rand_delay.sv
// Bench for vc_test_rand_delay: three instances (max delay 0, 7, 255) checked every
// cycle against a timestamp-based model, plus directed latency/reset/determinism cases.
module tb_vc_test_rand_delay;

    localparam int NI = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       in_val  [NI];
    logic       in_rdy  [NI];
    logic [7:0] in_msg  [NI];
    logic       out_val [NI];
    logic       out_rdy [NI];
    logic [7:0] out_msg [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vc_test_rand_delay #(.p_msg_sz(8), .p_max_delay(0), .p_seed(16'hb1)) u_dut0 (
        .clk(clk), .reset(reset), .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_msg(in_msg[0]),
        .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg[0])
    );
    vc_test_rand_delay #(.p_msg_sz(8), .p_max_delay(7), .p_seed(16'h1234)) u_dut1 (
        .clk(clk), .reset(reset), .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_msg(in_msg[1]),
        .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg[1])
    );
    vc_test_rand_delay #(.p_msg_sz(8), .p_max_delay(255), .p_seed(16'hb1)) u_dut2 (
        .clk(clk), .reset(reset), .in_val(in_val[2]), .in_rdy(in_rdy[2]), .in_msg(in_msg[2]),
        .out_val(out_val[2]), .out_rdy(out_rdy[2]), .out_msg(out_msg[2])
    );

    function automatic int max_d(int i);
        if (i == 0) return 0;
        if (i == 1) return 7;
        return 255;
    endfunction

    function automatic logic [15:0] seed_of(int i);
        return (i == 1) ? 16'h1234 : 16'hb1;
    endfunction

    function automatic logic [15:0] lfsr_step(logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hb400 : 16'h0000);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a message is visible from its ready cycle until taken downstream.
    bit         m_full  [NI];
    logic [7:0] m_msg   [NI];
    int         m_ready [NI];
    logic [15:0] m_lfsr [NI];
    int         cyc = 0;
    logic       ev, er;
    logic [7:0] em;
    int         md;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            ev = 1'b0;
            er = 1'b0;
            em = 8'h00;
            if (reset) begin
                ev = m_full[i] && (cyc >= m_ready[i]);
                er = !m_full[i] || (ev && out_rdy[i]);
                em = m_msg[i];
            end
            chk($sformatf("u%0d out_val", i), 32'(out_val[i]), 32'(ev));
            chk($sformatf("u%0d in_rdy", i), 32'(in_rdy[i]), 32'(er));
            if (ev || !reset) chk($sformatf("u%0d out_msg", i), 32'(out_msg[i]), 32'(em));
            if (!reset) begin
                m_full[i] = 1'b0;
                m_msg[i]  = 8'h00;
                m_lfsr[i] = seed_of(i);
            end else begin
                if (ev && out_rdy[i]) m_full[i] = 1'b0;
                if (in_val[i] && er) begin
                    md         = int'(m_lfsr[i][7:0]) % (max_d(i) + 1);
                    m_full[i]  = 1'b1;
                    m_msg[i]   = in_msg[i];
                    m_ready[i] = cyc + 1 + md;
                    m_lfsr[i]  = lfsr_step(m_lfsr[i]);
                end
            end
        end
    end

    // Observed per-message delay on u_dut1, recorded per run.
    int obs0[$];
    int obs1[$];
    int acc_q[$];
    bit fresh   = 1'b1;
    int mcyc    = 0;
    int rec_run = -1;
    int mon_d;

    always @(negedge clk) begin
        mcyc++;
        if (!reset) begin
            acc_q.delete();
            fresh = 1'b1;
        end else if (rec_run >= 0) begin
            if (out_val[1] && fresh && acc_q.size() > 0) begin
                mon_d = mcyc - acc_q.pop_front() - 1;
                if (rec_run == 0) obs0.push_back(mon_d);
                else obs1.push_back(mon_d);
            end
            fresh = !out_val[1] || out_rdy[1];
            if (in_val[1] && in_rdy[1]) acc_q.push_back(mcyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          lat1, lat2, seen, sent;
    logic [15:0] el;
    int          ed;

    initial begin
        for (int i = 0; i < NI; i++) begin
            in_val[i]  = 1'b0;
            in_msg[i]  = 8'h00;
            out_rdy[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Pass-through: aa..ff back to back, one-cycle latency.
        for (int k = 0; k < 7; k++) begin
            in_val[0] = (k < 6);
            in_msg[0] = 8'(8'haa + 8'h11 * k);
            @(negedge clk);
            chk("pt_rdy", 32'(in_rdy[0]), 32'd1);
            if (k == 0) begin
                chk("pt_idle_val", 32'(out_val[0]), 32'd0);
            end else begin
                chk("pt_val", 32'(out_val[0]), 32'd1);
                chk("pt_msg", 32'(out_msg[0]), 32'(8'(8'haa + 8'h11 * (k - 1))));
            end
            @(posedge clk);
            #1;
        end
        in_val[0] = 1'b0;

        // First-message latency straight out of reset: 1 + seed[7:0] % (max+1).
        in_val[1] = 1'b1;
        in_msg[1] = 8'h11;
        in_val[2] = 1'b1;
        in_msg[2] = 8'h22;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_val[1] = 1'b0;
        in_val[2] = 1'b0;
        lat1 = -1;
        lat2 = -1;
        for (int n = 1; n <= 300 && (lat1 < 0 || lat2 < 0); n++) begin
            @(negedge clk);
            if (lat1 < 0 && out_val[1]) lat1 = n;
            if (lat2 < 0 && out_val[2]) lat2 = n;
        end
        chk("lat_max7_seed1234", 32'(lat1), 32'd5);
        chk("lat_max255_seedb1", 32'(lat2), 32'd178);

        // Back-pressure in HOLD: message pinned, new input refused.
        @(posedge clk);
        #1;
        out_rdy[1] = 1'b0;
        in_val[1]  = 1'b1;
        in_msg[1]  = 8'h5a;
        @(posedge clk);
        #1;
        in_msg[1] = 8'ha5;
        for (int n = 0; n < 20 && !out_val[1]; n++) @(negedge clk);
        chk("hold_reached", 32'(out_val[1]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_val", 32'(out_val[1]), 32'd1);
            chk("hold_msg", 32'(out_msg[1]), 32'h5a);
            chk("hold_rdy", 32'(in_rdy[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        in_val[1]  = 1'b0;
        out_rdy[1] = 1'b1;

        // Reset during DELAY: second message on u_dut2 has delay 0x58 = 88.
        in_val[2] = 1'b1;
        in_msg[2] = 8'hc3;
        @(negedge clk);
        chk("dly_accept_rdy", 32'(in_rdy[2]), 32'd1);
        @(posedge clk);
        #1;
        in_val[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("dly_val", 32'(out_val[2]), 32'd0);
        chk("dly_rdy", 32'(in_rdy[2]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_val", 32'(out_val[2]), 32'd0);
        chk("rst_rdy", 32'(in_rdy[2]), 32'd0);
        chk("rst_msg", 32'(out_msg[2]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_after_rdy", 32'(in_rdy[2]), 32'd1);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_val[2]) seen++;
        end
        chk("rst_discarded", 32'(seen), 32'd0);

        // Random traffic with occasional resets; the model checks every cycle.
        repeat (3000) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NI; i++) begin
                in_val[i]  = ($urandom_range(0, 9) < 6);
                in_msg[i]  = 8'($urandom);
                out_rdy[i] = ($urandom_range(0, 9) < 7);
            end
        end

        // Determinism: two runs of 32 messages, different handshake timing.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            for (int i = 0; i < NI; i++) begin
                in_val[i]  = 1'b0;
                out_rdy[i] = 1'b1;
            end
            @(posedge clk);
            #1;
            reset   = 1'b1;
            rec_run = r;
            sent    = 0;
            for (int c = 0; c < 2000 && sent < 32; c++) begin
                in_val[1]  = ($urandom_range(0, 1) == 1);
                in_msg[1]  = 8'($urandom);
                out_rdy[1] = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_val[1] && in_rdy[1]) sent++;
                @(posedge clk);
                #1;
            end
            in_val[1]  = 1'b0;
            out_rdy[1] = 1'b1;
            repeat (20) @(posedge clk);
            #1 rec_run = -1;
        end
        chk("det_count0", 32'(obs0.size()), 32'd32);
        chk("det_count1", 32'(obs1.size()), 32'd32);
        el = 16'h1234;
        for (int k = 0; k < 32; k++) begin
            ed = int'(el[7:0]) % 8;
            el = lfsr_step(el);
            if (k < obs0.size()) chk($sformatf("det_model[%0d]", k), 32'(obs0[k]), 32'(ed));
            if (k < obs0.size() && k < obs1.size())
                chk($sformatf("det_repeat[%0d]", k), 32'(obs1[k]), 32'(obs0[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
